// File: rtl/nic_cmd_responder.sv
// nic_cmd_responder: terminating end of the HPU command path for the NIC
// outbound interface. It forwards NICSend descriptors to the NIC, tracks every
// accepted command in order, and returns one response per command once the
// matching NIC completion (or, for misrouted commands, its turn) arrives.

package nic_cmd_pkg;

  typedef struct packed {
    logic [1:0] cluster_id;
    logic [2:0] core_id;
    logic [1:0] local_id;
  } cmd_id_t;

  typedef enum logic [1:0] {
    HostMemCpy = 2'd0,
    HostDirect = 2'd1,
    NICSend    = 2'd2
  } cmd_type_t;

  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] length;
  } nic_cmd_t;

  typedef struct packed {
    nic_cmd_t nic_cmd;
  } cmd_descr_t;

  typedef struct packed {
    logic       generate_event;
    cmd_id_t    cmd_id;
    cmd_type_t  cmd_type;
    cmd_descr_t descr;
  } pspin_cmd_t;

  typedef struct packed {
    cmd_id_t     cmd_id;
    logic [31:0] imm_data;
  } pspin_cmd_resp_t;

endpackage

module nic_cmd_responder
  import nic_cmd_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            cmd_valid_i,
  output logic                            cmd_ready_o,
  input  pspin_cmd_t                      cmd_i,
  output logic                            nic_cmd_valid_o,
  input  logic                            nic_cmd_ready_i,
  output nic_cmd_t                        nic_cmd_o,
  input  logic                            nic_done_i,
  output logic                            resp_valid_o,
  input  logic                            resp_ready_i,
  output pspin_cmd_resp_t                 resp_o,
  output logic [$clog2(MAX_INFLIGHT):0]   inflight_o,
  output logic                            err_spurious_o
);

  localparam int AW = $clog2(MAX_INFLIGHT);
  localparam int PW = AW + 1;

  // Tracker storage: command id plus "was forwarded to the NIC" flag.
  cmd_id_t       id_mem  [MAX_INFLIGHT];
  logic          fwd_mem [MAX_INFLIGHT];
  logic [PW-1:0] wptr, rptr;

  // fcnt: forwarded entries in the tracker; dcnt: completions not yet matched.
  logic [PW-1:0] fcnt, dcnt, fwd_out;

  logic     nic_vld_p1, resp_vld_p1, err_q;
  nic_cmd_t nic_cmd_p1;
  pspin_cmd_resp_t resp_p1;

  logic full, empty, acc, is_fwd, push_fwd;
  logic head_fwd, slot_free, pop, fwd_pop, spurious, done_ok;
  logic unused_gen;

  // generate_event has no meaning at this endpoint; every command is answered.
  assign unused_gen = cmd_i.generate_event;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  assign cmd_ready_o = !full && (!nic_vld_p1 || nic_cmd_ready_i);
  assign acc         = cmd_valid_i && cmd_ready_o;
  assign is_fwd      = (cmd_i.cmd_type == NICSend);
  assign push_fwd    = acc && is_fwd;

  assign fwd_out  = fcnt - dcnt;
  assign spurious = nic_done_i && (fwd_out == '0);
  assign done_ok  = nic_done_i && !spurious;

  // A forwarded head may pop on a stored completion or one arriving this cycle.
  assign head_fwd  = fwd_mem[rptr[AW-1:0]];
  assign slot_free = !resp_vld_p1 || resp_ready_i;
  assign pop       = !empty && slot_free && (head_fwd ? ((dcnt != '0) || done_ok) : 1'b1);
  assign fwd_pop   = pop && head_fwd;

  assign nic_cmd_valid_o = nic_vld_p1;
  assign nic_cmd_o       = nic_cmd_p1;
  assign resp_valid_o    = resp_vld_p1;
  assign resp_o          = resp_p1;
  assign inflight_o      = wptr - rptr;
  assign err_spurious_o  = err_q;

  // Tracker payload write; pointers guard validity so no reset is needed here.
  always_ff @(posedge clk_i) begin
    if (acc) begin
      id_mem[wptr[AW-1:0]]  <= cmd_i.cmd_id;
      fwd_mem[wptr[AW-1:0]] <= is_fwd;
    end
  end

  // Tracker pointers, wrap bit above the index distinguishes full from empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (acc) wptr <= wptr + PW'(1);
      if (pop) rptr <= rptr + PW'(1);
    end
  end

  // Forwarded-entry count and unmatched-completion count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fcnt <= '0;
      dcnt <= '0;
    end else begin
      if (push_fwd && !fwd_pop)      fcnt <= fcnt + PW'(1);
      else if (!push_fwd && fwd_pop) fcnt <= fcnt - PW'(1);
      if (done_ok && !fwd_pop)       dcnt <= dcnt + PW'(1);
      else if (!done_ok && fwd_pop)  dcnt <= dcnt - PW'(1);
    end
  end

  // Stage p1: NIC descriptor register, held under backpressure, reloadable on handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      nic_vld_p1 <= 1'b0;
      nic_cmd_p1 <= '0;
    end else if (push_fwd) begin
      nic_vld_p1 <= 1'b1;
      nic_cmd_p1 <= cmd_i.descr.nic_cmd;
    end else if (nic_cmd_ready_i) begin
      nic_vld_p1 <= 1'b0;
    end
  end

  // Stage p1: response register, loaded from the tracker head on pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_vld_p1 <= 1'b0;
      resp_p1     <= '0;
    end else if (pop) begin
      resp_vld_p1      <= 1'b1;
      resp_p1.cmd_id   <= id_mem[rptr[AW-1:0]];
      resp_p1.imm_data <= '0;
    end else if (resp_ready_i) begin
      resp_vld_p1 <= 1'b0;
    end
  end

  // Sticky flag for completions that have no forwarded command to match.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       err_q <= 1'b0;
    else if (spurious) err_q <= 1'b1;
  end

endmodule

// File: tb/tb_nic_cmd_responder.sv
// Testbench for nic_cmd_responder: directed scenarios followed by a randomized
// run checked against a transaction-level reference model (ordered queues).
module tb_nic_cmd_responder;
  import nic_cmd_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_valid;
  logic            cmd_ready;
  pspin_cmd_t      cmd;
  logic            nic_valid;
  logic            nic_ready;
  nic_cmd_t        nic_cmd;
  logic            done;
  logic            resp_valid;
  logic            resp_ready;
  pspin_cmd_resp_t resp;
  logic [3:0]      inflight;
  logic            err;

  int checks = 0;
  int errors = 0;

  nic_cmd_responder #(.MAX_INFLIGHT(8)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .cmd_i          (cmd),
    .nic_cmd_valid_o(nic_valid),
    .nic_cmd_ready_i(nic_ready),
    .nic_cmd_o      (nic_cmd),
    .nic_done_i     (done),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_o         (resp),
    .inflight_o     (inflight),
    .err_spurious_o (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] id;
    logic       fwd;
  } exp_t;

  exp_t     resp_q[$];
  nic_cmd_t nic_q[$];
  int       nic_hs, dones, fwd_resp;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic pspin_cmd_t mk(input cmd_type_t t, input logic [6:0] id,
                                    input logic [31:0] addr, input logic [31:0] len);
    pspin_cmd_t c;
    c = '0;
    c.cmd_type = t;
    c.cmd_id = id;
    c.descr.nic_cmd.src_addr = addr;
    c.descr.nic_cmd.length = len;
    return c;
  endfunction

  function automatic logic [79:0] rsp(input logic [6:0] id);
    pspin_cmd_resp_t r;
    r.cmd_id = id;
    r.imm_data = 32'd0;
    return 80'(r);
  endfunction

  // Model bookkeeping for one cycle; called with inputs stable before the edge.
  task automatic observe();
    exp_t e;
    nic_cmd_t d;
    if (nic_valid && nic_ready) begin
      if (nic_q.size() == 0) check("nic_extra", 80'(1), 80'(0));
      else begin
        d = nic_q.pop_front();
        check("nic_desc", 80'(nic_cmd), 80'(d));
      end
      nic_hs++;
    end
    if (resp_valid && resp_ready) begin
      if (resp_q.size() == 0) check("resp_extra", 80'(1), 80'(0));
      else begin
        e = resp_q.pop_front();
        check("resp_order", 80'(resp), rsp(e.id));
        if (e.fwd) begin
          fwd_resp++;
          check("resp_before_done", 80'(fwd_resp <= dones), 80'(1));
        end
      end
    end
    if (cmd_valid && cmd_ready) begin
      e.id = cmd.cmd_id;
      e.fwd = (cmd.cmd_type == NICSend);
      resp_q.push_back(e);
      if (e.fwd) nic_q.push_back(cmd.descr.nic_cmd);
    end
    check("inflight_bound", 80'(inflight <= 4'd8), 80'(1));
  endtask

  pspin_cmd_t  c1, ca, cb;
  logic [6:0]  ids [8];
  int          rt, guard;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd = '0; nic_ready = 1'b1;
    done = 1'b0; resp_ready = 1'b1;
    #1;
    check("rst_nic_valid", 80'(nic_valid), 80'(0));
    check("rst_resp_valid", 80'(resp_valid), 80'(0));
    check("rst_err", 80'(err), 80'(0));
    check("rst_inflight", 80'(inflight), 80'(0));
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("idle_cmd_ready", 80'(cmd_ready), 80'(1));

    // Single NICSend round trip
    c1 = mk(NICSend, 7'b10_101_11, 32'hDEAD_0000, 32'd256);
    cmd = c1; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("t1_nic_valid", 80'(nic_valid), 80'(1));
    check("t1_nic_cmd", 80'(nic_cmd), 80'(c1.descr.nic_cmd));
    check("t1_inflight1", 80'(inflight), 80'(1));
    tick();
    check("t1_nic_cleared", 80'(nic_valid), 80'(0));
    check("t1_no_resp", 80'(resp_valid), 80'(0));
    done = 1'b1;
    tick();
    done = 1'b0;
    check("t1_resp_valid", 80'(resp_valid), 80'(1));
    check("t1_resp", 80'(resp), rsp(7'b1010111));
    check("t1_inflight0", 80'(inflight), 80'(0));
    tick();
    check("t1_resp_done", 80'(resp_valid), 80'(0));

    // Fill the tracker
    for (int i = 0; i < 8; i++) begin
      ids[i] = 7'(8'h20 + i);
      cmd = mk(NICSend, ids[i], 32'h1000 + 32'(i), 32'd64);
      cmd_valid = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    check("t2_inflight8", 80'(inflight), 80'(8));
    check("t2_full_ready", 80'(cmd_ready), 80'(0));
    tick();
    check("t2_full_ready2", 80'(cmd_ready), 80'(0));
    done = 1'b1;
    tick();
    done = 1'b0;
    check("t2_resp0", 80'(resp), rsp(ids[0]));
    check("t2_inflight7", 80'(inflight), 80'(7));
    check("t2_ready_again", 80'(cmd_ready), 80'(1));
    tick();
    for (int i = 1; i < 8; i++) begin
      done = 1'b1;
      tick();
      check("t2_resp_seq", 80'(resp), rsp(ids[i]));
      check("t2_resp_seq_valid", 80'(resp_valid), 80'(1));
    end
    done = 1'b0;
    tick();
    check("t2_drained", 80'(inflight), 80'(0));
    check("t2_resp_idle", 80'(resp_valid), 80'(0));

    // NIC backpressure
    ca = mk(NICSend, 7'h31, 32'hA000, 32'd16);
    cb = mk(NICSend, 7'h32, 32'hB000, 32'd32);
    nic_ready = 1'b0;
    cmd = ca; cmd_valid = 1'b1;
    tick();
    cmd = cb;
    for (int k = 0; k < 5; k++) begin
      check("t3_bp_ready", 80'(cmd_ready), 80'(0));
      check("t3_bp_hold", 80'(nic_cmd), 80'(ca.descr.nic_cmd));
      check("t3_bp_valid", 80'(nic_valid), 80'(1));
      tick();
    end
    nic_ready = 1'b1;
    #1;
    check("t3_release_ready", 80'(cmd_ready), 80'(1));
    tick();
    cmd_valid = 1'b0;
    check("t3_second_valid", 80'(nic_valid), 80'(1));
    check("t3_second_cmd", 80'(nic_cmd), 80'(cb.descr.nic_cmd));
    tick();
    check("t3_nic_idle", 80'(nic_valid), 80'(0));
    done = 1'b1;
    tick();
    check("t3_resp_a", 80'(resp), rsp(7'h31));
    tick();
    done = 1'b0;
    check("t3_resp_b", 80'(resp), rsp(7'h32));
    tick();

    // HostMemCpy behind a NICSend
    cmd = mk(NICSend, 7'h41, 32'hC000, 32'd8); cmd_valid = 1'b1;
    tick();
    cmd = mk(HostMemCpy, 7'h42, 32'hD000, 32'd8);
    tick();
    cmd_valid = 1'b0;
    check("t4_no_nic_for_copy", 80'(nic_valid), 80'(0));
    check("t4_inflight2", 80'(inflight), 80'(2));
    tick();
    check("t4_copy_waits", 80'(resp_valid), 80'(0));
    check("t4_no_nic_for_copy2", 80'(nic_valid), 80'(0));
    done = 1'b1;
    tick();
    done = 1'b0;
    check("t4_resp_send", 80'(resp), rsp(7'h41));
    tick();
    check("t4_resp_copy", 80'(resp), rsp(7'h42));
    check("t4_resp_copy_valid", 80'(resp_valid), 80'(1));
    tick();
    check("t4_idle", 80'(resp_valid), 80'(0));
    check("t4_inflight0", 80'(inflight), 80'(0));

    // Response backpressure with three completions
    for (int i = 0; i < 3; i++) begin
      ids[i] = 7'(8'h50 + i);
      cmd = mk(NICSend, ids[i], 32'hE000 + 32'(i), 32'd4);
      cmd_valid = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    tick();
    resp_ready = 1'b0;
    done = 1'b1;
    tick(); tick(); tick();
    done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check("t5_hold_resp", 80'(resp), rsp(ids[0]));
      check("t5_hold_valid", 80'(resp_valid), 80'(1));
      tick();
    end
    resp_ready = 1'b1;
    tick();
    check("t5_resp1", 80'(resp), rsp(ids[1]));
    tick();
    check("t5_resp2", 80'(resp), rsp(ids[2]));
    check("t5_resp2_valid", 80'(resp_valid), 80'(1));
    tick();
    check("t5_idle", 80'(resp_valid), 80'(0));

    // Spurious completion on an empty tracker
    done = 1'b1;
    tick();
    done = 1'b0;
    check("t6_err_set", 80'(err), 80'(1));
    check("t6_no_resp", 80'(resp_valid), 80'(0));
    check("t6_inflight0", 80'(inflight), 80'(0));
    cmd = mk(NICSend, 7'h61, 32'hF000, 32'd1); cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t6_dcnt_zero", 80'(resp_valid), 80'(0));
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    check("t6_resp", 80'(resp), rsp(7'h61));
    tick();
    check("t6_err_sticky", 80'(err), 80'(1));

    // Asynchronous reset mid-stream
    nic_ready = 1'b0;
    cmd = mk(NICSend, 7'h71, 32'h7000, 32'd2); cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("t7_pre_valid", 80'(nic_valid), 80'(1));
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_nic_valid", 80'(nic_valid), 80'(0));
    check("t7_rst_nic_cmd", 80'(nic_cmd), 80'(0));
    check("t7_rst_resp_valid", 80'(resp_valid), 80'(0));
    check("t7_rst_resp", 80'(resp), 80'(0));
    check("t7_rst_err", 80'(err), 80'(0));
    check("t7_rst_inflight", 80'(inflight), 80'(0));
    @(posedge clk);
    #3 rst_n = 1'b1;
    nic_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t7_no_lost_resp", 80'(resp_valid), 80'(0));
      check("t7_no_nic", 80'(nic_valid), 80'(0));
    end

    // Randomized traffic against the ordered-queue model
    nic_hs = 0; dones = 0; fwd_resp = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rt = int'($urandom_range(0, 5));
      cmd = mk(rt == 0 ? HostMemCpy : (rt == 1 ? HostDirect : NICSend),
               7'($urandom), $urandom, $urandom);
      cmd.generate_event = 1'($urandom);
      cmd_valid  = ($urandom_range(0, 3) != 0);
      nic_ready  = ($urandom_range(0, 3) != 0);
      resp_ready = ($urandom_range(0, 3) != 0);
      done = (nic_hs > dones) && ($urandom_range(0, 2) == 0);
      if (done) dones++;
      @(negedge clk);
      observe();
      tick();
    end
    cmd_valid = 1'b0; nic_ready = 1'b1; resp_ready = 1'b1;
    guard = 0;
    while ((resp_q.size() != 0 || nic_q.size() != 0) && guard < 500) begin
      done = (nic_hs > dones);
      if (done) dones++;
      @(negedge clk);
      observe();
      tick();
      guard++;
    end
    done = 1'b0;
    tick();
    check("rand_drain_timeout", 80'(guard < 500), 80'(1));
    check("rand_resp_left", 80'(resp_q.size()), 80'(0));
    check("rand_inflight0", 80'(inflight), 80'(0));
    check("rand_no_spurious", 80'(err), 80'(0));
    check("rand_resp_idle", 80'(resp_valid), 80'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nic_cmd_responder.md
Name: nic_cmd_responder

Overview:
- Terminating end of the HPU command path for interface `CMD_NIC_OUTBOUND_ID`.
- Accepts `pspin_cmd_t` from the cmd unit and forwards NICSend descriptors (`nic_cmd_t`) to the NIC outbound engine.
- Tracks outstanding commands in order and returns one `pspin_cmd_resp_t` per accepted command once the NIC signals completion, so the issuing HPU can free its `local_cmd_id` slot.

Parameters:
- MAX_INFLIGHT, 8: depth of the in-order tracking FIFO (accepted but not yet responded); power of 2, ≥2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command ready
- cmd_i  in  $bits(pspin_cmd_t)  incoming command
- nic_cmd_valid_o  out  1  NIC descriptor valid
- nic_cmd_ready_i  in  1  NIC descriptor ready
- nic_cmd_o  out  $bits(nic_cmd_t)  descriptor (`cmd_i.descr.nic_cmd`)
- nic_done_i  in  1  single-cycle pulse; one NIC command completed, in issue order
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response ready
- resp_o  out  $bits(pspin_cmd_resp_t)  `{cmd_id, imm_data}`; cmd_id is 7 b
- inflight_o  out  $clog2(MAX_INFLIGHT)+1  tracker occupancy
- err_spurious_o  out  1  sticky: nic_done_i seen with no forwarded command outstanding

Behaviour:
- Reset values:
  - `nic_cmd_valid_o`, `resp_valid_o`, `err_spurious_o` = 0.
  - `inflight_o` = 0.
  - Tracker empty; done counter 0; output registers zero.
  - Reset mid-operation discards all state; no response is emitted for lost commands.
- Accept: `acc = cmd_valid_i & cmd_ready_o`.
  - `cmd_ready_o = !tracker_full & (!nic_cmd_valid_o | nic_cmd_ready_i)`.
  - Combinational from `nic_cmd_ready_i` only; no dependency on `cmd_valid_i`.
- On `acc`:
  - Push `{cmd_id, fwd}` into the tracker, where `fwd = (cmd_type == NICSend)`.
  - If `fwd`: load the NIC output register next cycle and set `nic_cmd_valid_o`. Accept-to-valid latency is 1 cycle.
  - If not `fwd` (HostMemCpy/HostDirect misrouted): no NIC traffic; the command still receives a response.
- NIC output register:
  - Holds stable while `nic_cmd_valid_o & !nic_cmd_ready_i`.
  - Clears on handshake unless reloaded by a same-cycle `acc`, which gives back-to-back throughput of 1/cycle.
- Done counter `dcnt`:
  - Counts NIC completions not yet matched to the tracker head.
  - `fwd_out` counts forwarded commands still in the tracker that have not been matched by `dcnt`.
  - `nic_done_i` when `fwd_out == 0`: pulse ignored, `err_spurious_o` set (cleared only by reset).
  - Completions may arrive while the descriptor is still in the output register only if the NIC misbehaves; this is treated as spurious only when `fwd_out == 0`.
- Pop condition at the tracker head: `!tracker_empty & resp_slot_free & (head.fwd ? (dcnt > 0 | nic_done_i) : 1)`.
  - `resp_slot_free = !resp_valid_o | resp_ready_i`.
  - On pop: load `resp_o.cmd_id = head.cmd_id` and `resp_o.imm_data = 0`; set `resp_valid_o` the next cycle. Done-to-response latency is 1 cycle.
  - Simultaneous done and fwd-pop: `dcnt` unchanged. Done only: `dcnt+1`. Pop only: `dcnt-1`.
- Ordering: responses are strictly in acceptance order. A non-fwd command behind a fwd head waits for the head to pop.
- `generate_event` is ignored here; every command gets a response.
- `resp_o` is held stable while `resp_valid_o & !resp_ready_i`.
- Simultaneous push and pop on a full tracker: push is not allowed when full (`cmd_ready_o = 0`); a pop on that cycle frees a slot for the next cycle.
- Pointers wrap modulo MAX_INFLIGHT; an extra wrap bit distinguishes full from empty.
- `inflight_o` = number of tracker entries, updated the cycle after push/pop.

Test Plan:
- Reset, then one NICSend with `cmd_id={cl=2,core=5,local=3}`, length=256, `nic_cmd_ready_i=1` → `nic_cmd_valid_o` 1 cycle after accept with matching fields. `nic_done_i` pulse at t → `resp_valid_o` at t+1 with cmd_id `7'b10_101_11`, imm_data=0; `inflight_o` 1→0.
- 8 NICSends with `nic_cmd_ready_i=1` and no dones → `cmd_ready_o=0` after the 8th with `inflight_o=8`. One done plus resp_ready → one response, then `cmd_ready_o=1`.
- NIC backpressure: `nic_cmd_ready_i=0` for 5 cycles with two commands offered → first descriptor held stable, `cmd_ready_o=0`. Ready released → both forwarded on consecutive cycles.
- HostMemCpy (`cmd_type=0`) queued behind a NICSend → no `nic_cmd_valid_o` for it. Response order is NICSend then HostMemCpy, the latter 1 cycle after the former when `resp_ready_i=1`.
- `nic_done_i` pulse with empty tracker → `err_spurious_o=1` stays set, no response, `dcnt=0`. Async reset low mid-stream → all outputs 0 immediately, `inflight_o=0`.
- `resp_ready_i=0` for 10 cycles with 3 dones → `resp_o` stable. After release, 3 responses on 3 consecutive cycles in order.
